// File: rtl/ni_cmd_intf_if.sv
// NI controller command bus: the asynchronous NI pins plus the register-bank side.
// The slave modport is the command interface; the master modport is the NI/bank side.
interface ni_cmd_intf_if #(
    parameter int MAX_BYTES = 3
);
    logic [7:0]             ad_in;
    logic                   ale;
    logic                   mod_sel;
    logic                   cmd_stb;
    logic [5:0]             cmd_idx;
    logic [1:0]             cmd_mod;
    logic [8*MAX_BYTES-1:0] cmd_data;
    logic                   rd_req;
    logic [7:0]             rd_data;
    logic                   rd_valid;
    logic [7:0]             ad_out;
    logic                   ad_oe;
    logic [3:0]             err;
    logic                   busy;

    modport slave (
        input  ad_in, ale, mod_sel, rd_data, rd_valid,
        output cmd_stb, cmd_idx, cmd_mod, cmd_data, rd_req, ad_out, ad_oe, err, busy
    );

    modport master (
        output ad_in, ale, mod_sel, rd_data, rd_valid,
        input  cmd_stb, cmd_idx, cmd_mod, cmd_data, rd_req, ad_out, ad_oe, err, busy
    );
endinterface

// File: rtl/ni_cmd_intf.sv
// Decodes NI controller header/data bytes into command strobes and serves read data.
// Optional transaction timeout is built only when NI_INTF_TMO_EN is defined.
module ni_cmd_intf #(
    parameter int                   NUM_CMD   = 19,
    parameter int                   MAX_BYTES = 3,
    parameter logic [3*NUM_CMD-1:0] CMD_LEN   = {NUM_CMD{3'd1}},
    parameter logic [NUM_CMD-1:0]   RD_MASK   = '0,
    parameter int                   TMO_CYC   = 1024
) (
    input logic          clk,
    input logic          rst,
    ni_cmd_intf_if.slave bus
);
    typedef enum logic [2:0] {IDLE, HDR, DATA, RDWAIT, RDDRV, DRAIN} state_t;

    state_t                 r_state;
    logic [7:0]             r_ad_p0, r_ad_p1;
    logic                   r_ale_p0, r_ale_p1, r_ale_p2;
    logic                   r_sel_p0, r_sel_p1, r_sel_p2;
    logic                   r_cmd_stb, r_rd_req, r_ad_oe;
    logic [5:0]             r_cmd_idx;
    logic [1:0]             r_cmd_mod;
    logic [8*MAX_BYTES-1:0] r_cmd_data;
    logic [7:0]             r_ad_out;
    logic [3:0]             r_err;
    logic [2:0]             r_cnt, r_len;

    logic       w_ale_fall, w_sel_rise, w_sel_fall, w_tmo_hit;
    logic       w_hdr_ok, w_hdr_rd;
    logic [7:0] w_byte;
    logic [5:0] w_idx;
    logic [2:0] w_hdr_len;

    function automatic logic [2:0] len_of(input logic [5:0] idx);
        logic [2:0] v;
        v = '0;
        for (int i = 0; i < NUM_CMD; i++)
            if (idx == 6'(i)) v = CMD_LEN[3*i +: 3];
        return v;
    endfunction

    function automatic logic is_rd(input logic [5:0] idx);
        logic v;
        v = 1'b0;
        for (int i = 0; i < NUM_CMD; i++)
            if (idx == 6'(i)) v = RD_MASK[i];
        return v;
    endfunction

    // Edges are taken from the synchronized copies; the byte is the synchronized bus.
    assign w_ale_fall = r_ale_p2 & ~r_ale_p1;
    assign w_sel_rise = ~r_sel_p2 & r_sel_p1;
    assign w_sel_fall = r_sel_p2 & ~r_sel_p1;
    assign w_byte     = r_ad_p1;
    assign w_idx      = w_byte[7:2];
    assign w_hdr_ok   = (32'(w_idx) < NUM_CMD);
    assign w_hdr_rd   = is_rd(w_idx);
    assign w_hdr_len  = len_of(w_idx);

`ifdef NI_INTF_TMO_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0] r_tmo;

    // Cleared outside the timed states and on every accepted byte.
    always_ff @(posedge clk) begin
        if (rst || !(r_state inside {HDR, DATA, RDWAIT}) ||
            (w_ale_fall && !w_sel_fall && (r_state inside {HDR, DATA})))
            r_tmo <= '0;
        else
            r_tmo <= r_tmo + 1'b1;
    end

    assign w_tmo_hit = (r_tmo == TW'(TMO_CYC - 1));
`else
    assign w_tmo_hit = (TMO_CYC < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ad_p0    <= '0;
            r_ad_p1    <= '0;
            r_ale_p0   <= 1'b0;
            r_ale_p1   <= 1'b0;
            r_ale_p2   <= 1'b0;
            r_sel_p0   <= 1'b0;
            r_sel_p1   <= 1'b0;
            r_sel_p2   <= 1'b0;
            r_cmd_stb  <= 1'b0;
            r_rd_req   <= 1'b0;
            r_ad_oe    <= 1'b0;
            r_cmd_idx  <= '0;
            r_cmd_mod  <= '0;
            r_cmd_data <= '0;
            r_ad_out   <= '0;
            r_err      <= '0;
            r_cnt      <= '0;
            r_len      <= '0;
        end else begin
            r_ad_p0   <= bus.ad_in;
            r_ad_p1   <= r_ad_p0;
            r_ale_p0  <= bus.ale;
            r_ale_p1  <= r_ale_p0;
            r_ale_p2  <= r_ale_p1;
            r_sel_p0  <= bus.mod_sel;
            r_sel_p1  <= r_sel_p0;
            r_sel_p2  <= r_sel_p1;
            r_cmd_stb <= 1'b0;
            r_rd_req  <= 1'b0;
            r_err     <= '0;
            // A coincident mod_sel fall always takes precedence over the ale fall.
            case (r_state)
                IDLE: if (w_sel_rise) r_state <= HDR;
                HDR: begin
                    if (w_sel_fall) begin
                        r_err[0] <= 1'b1;
                        r_state  <= IDLE;
                    end else if (w_ale_fall) begin
                        r_cmd_idx  <= w_idx;
                        r_cmd_mod  <= w_byte[1:0];
                        r_cmd_data <= '0;
                        r_cnt      <= '0;
                        r_len      <= w_hdr_len;
                        if (!w_hdr_ok) begin
                            r_err[2] <= 1'b1;
                            r_state  <= DRAIN;
                        end else if (w_hdr_rd) begin
                            r_rd_req <= 1'b1;
                            r_state  <= RDWAIT;
                        end else if (w_hdr_len == 3'd0) begin
                            r_cmd_stb <= 1'b1;
                            r_state   <= DRAIN;
                        end else begin
                            r_state <= DATA;
                        end
                    end else if (w_tmo_hit) begin
                        r_err[3] <= 1'b1;
                        r_state  <= DRAIN;
                    end
                end
                DATA: begin
                    if (w_sel_fall) begin
                        r_err[0] <= 1'b1;
                        r_state  <= IDLE;
                    end else if (w_ale_fall) begin
                        for (int k = 0; k < MAX_BYTES; k++)
                            if (r_cnt == 3'(k)) r_cmd_data[8*k +: 8] <= w_byte;
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt + 3'd1 == r_len) begin
                            r_cmd_stb <= 1'b1;
                            r_state   <= DRAIN;
                        end
                    end else if (w_tmo_hit) begin
                        r_err[3] <= 1'b1;
                        r_state  <= DRAIN;
                    end
                end
                RDWAIT: begin
                    if (w_sel_fall) begin
                        r_err[0] <= 1'b1;
                        r_state  <= IDLE;
                    end else begin
                        if (w_ale_fall) r_err[1] <= 1'b1;
                        if (bus.rd_valid) begin
                            r_ad_out <= bus.rd_data;
                            r_ad_oe  <= 1'b1;
                            r_state  <= RDDRV;
                        end else if (w_tmo_hit) begin
                            r_err[3] <= 1'b1;
                            r_state  <= DRAIN;
                        end
                    end
                end
                RDDRV: begin
                    if (w_sel_fall) begin
                        r_ad_oe <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_ale_fall) begin
                        r_err[1] <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_sel_fall) r_state <= IDLE;
                    else if (w_ale_fall) r_err[1] <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_stb  = r_cmd_stb;
    assign bus.cmd_idx  = r_cmd_idx;
    assign bus.cmd_mod  = r_cmd_mod;
    assign bus.cmd_data = r_cmd_data;
    assign bus.rd_req   = r_rd_req;
    assign bus.ad_out   = r_ad_out;
    assign bus.ad_oe    = r_ad_oe;
    assign bus.err      = r_err;
    assign bus.busy     = (r_state != IDLE);
endmodule

// File: tb/tb_ni_cmd_intf.sv
// Directed bench for ni_cmd_intf: writes, multi-byte write, read, bad header, aborts,
// reset mid-transaction and the timeout (active or absent depending on NI_INTF_TMO_EN).
module tb_ni_cmd_intf;
    localparam int NC = 19;
    localparam int MB = 3;
    // Command 0 has no data, command 14 takes three bytes, the rest take one.
    localparam logic [3*NC-1:0] P_LEN =
        (({NC{3'd1}} & ~(57'h7 << 42)) | (57'h3 << 42)) & ~57'h7;
    localparam logic [NC-1:0] P_RD = 19'h40000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0, n_fail = 0;
    int   n_stb = 0, n_rdq = 0;
    int   n_err [4] = '{0, 0, 0, 0};
    int   b_stb, b_rdq;
    int   b_err [4];
    logic found;

    ni_cmd_intf_if #(.MAX_BYTES(MB)) bus ();

    ni_cmd_intf #(
        .NUM_CMD(NC), .MAX_BYTES(MB), .CMD_LEN(P_LEN), .RD_MASK(P_RD), .TMO_CYC(16)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.cmd_stb) n_stb++;
        if (bus.rd_req) n_rdq++;
        for (int i = 0; i < 4; i++) if (bus.err[i]) n_err[i]++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_stb = n_stb;
        b_rdq = n_rdq;
        for (int i = 0; i < 4; i++) b_err[i] = n_err[i];
    endtask

    task automatic sel(input logic v);
        bus.mod_sel = v;
        tick(4);
    endtask

    task automatic send(input logic [7:0] b);
        bus.ad_in = b;
        tick(2);
        bus.ale = 1'b1;
        tick(2);
        bus.ale = 1'b0;
        tick(4);
    endtask

    initial begin
        bus.ad_in    = '0;
        bus.ale      = 1'b0;
        bus.mod_sel  = 1'b0;
        bus.rd_data  = '0;
        bus.rd_valid = 1'b0;
        tick(3);
        chk("rst_ctrl", {bus.cmd_stb, bus.rd_req, bus.ad_oe, bus.busy, bus.err}, 32'h0);
        chk("rst_cmd", {bus.cmd_idx, bus.cmd_mod, bus.cmd_data}, 32'h0);
        chk("rst_adout", bus.ad_out, 32'h0);
        rst = 1'b0;
        tick(2);

        // Single-byte write to command 2
        snap();
        sel(1'b1);
        chk("busy_hdr", bus.busy, 1);
        send(8'h08);
        send(8'hA5);
        chk("w1_stb", n_stb - b_stb, 1);
        chk("w1_idx", bus.cmd_idx, 2);
        chk("w1_mod", bus.cmd_mod, 0);
        chk("w1_data", bus.cmd_data, 32'h0000A5);
        chk("busy_drain", bus.busy, 1);
        sel(1'b0);
        chk("w1_err", (n_err[0] - b_err[0]) + (n_err[1] - b_err[1]) + (n_err[2] - b_err[2]), 0);
        chk("w1_idle", bus.busy, 0);
        chk("w1_hold", bus.cmd_data, 32'h0000A5);

        // Three-byte write to command 14 plus one surplus byte
        snap();
        sel(1'b1);
        send(8'h38);
        send(8'h11);
        send(8'h22);
        chk("w3_nostb", n_stb - b_stb, 0);
        send(8'h33);
        chk("w3_stb", n_stb - b_stb, 1);
        chk("w3_data", bus.cmd_data, 32'h332211);
        chk("w3_idx", bus.cmd_idx, 14);
        send(8'h44);
        chk("w3_ovr", n_err[1] - b_err[1], 1);
        chk("w3_keep", bus.cmd_data, 32'h332211);
        sel(1'b0);
        chk("w3_stb1", n_stb - b_stb, 1);
        chk("w3_short", n_err[0] - b_err[0], 0);

        // Read of command 18
        snap();
        sel(1'b1);
        bus.ad_in = 8'h48;
        tick(2);
        bus.ale = 1'b1;
        tick(2);
        bus.ale = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus.rd_req) found = 1'b1;
        end
        chk("rd_req_seen", found, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("rd_oe_wait", bus.ad_oe, 0);
        bus.rd_data  = 8'h5C;
        bus.rd_valid = 1'b1;
        tick(1);
        bus.rd_valid = 1'b0;
        bus.rd_data  = 8'h00;
        chk("rd_oe", bus.ad_oe, 1);
        chk("rd_out", bus.ad_out, 32'h5C);
        bus.rd_data  = 8'h77;
        bus.rd_valid = 1'b1;
        tick(1);
        bus.rd_valid = 1'b0;
        tick(5);
        chk("rd_oe_hold", bus.ad_oe, 1);
        chk("rd_out_hold", bus.ad_out, 32'h5C);
        sel(1'b0);
        chk("rd_oe_drop", bus.ad_oe, 0);
        chk("rd_cnt", n_rdq - b_rdq, 1);
        chk("rd_nostb", n_stb - b_stb, 0);
        chk("rd_short", n_err[0] - b_err[0], 0);
        bus.rd_data  = 8'h99;
        bus.rd_valid = 1'b1;
        tick(1);
        bus.rd_valid = 1'b0;
        tick(2);
        chk("rd_idle_ign", {bus.ad_oe, bus.ad_out}, 32'h05C);

        // Out-of-range header, then an aborted three-byte write
        snap();
        sel(1'b1);
        send(8'hFC);
        chk("bad_err2", n_err[2] - b_err[2], 1);
        chk("bad_none", (n_stb - b_stb) + (n_rdq - b_rdq), 0);
        sel(1'b0);
        chk("bad_silent", n_err[0] - b_err[0], 0);
        sel(1'b1);
        send(8'h38);
        send(8'h01);
        sel(1'b0);
        chk("abort_err0", n_err[0] - b_err[0], 1);
        chk("abort_nostb", n_stb - b_stb, 0);
        chk("abort_idle", bus.busy, 0);

        // Zero-length write to command 0 with modifier 1
        snap();
        sel(1'b1);
        send(8'h01);
        chk("z_stb", n_stb - b_stb, 1);
        chk("z_cmd", {bus.cmd_idx, bus.cmd_mod, bus.cmd_data}, {6'd0, 2'd1, 24'h0});
        sel(1'b0);

        // Reset in the middle of a data phase
        snap();
        sel(1'b1);
        send(8'h38);
        send(8'h11);
        chk("mid_busy", bus.busy, 1);
        rst = 1'b1;
        bus.mod_sel = 1'b0;
        tick(4);
        rst = 1'b0;
        tick(2);
        chk("rstm_ctrl", {bus.cmd_stb, bus.rd_req, bus.ad_oe, bus.busy, bus.err}, 32'h0);
        chk("rstm_cmd", {bus.cmd_idx, bus.cmd_mod, bus.cmd_data}, 32'h0);
        chk("rstm_out", bus.ad_out, 32'h0);
        chk("rstm_noerr", (n_err[0] - b_err[0]) + (n_err[1] - b_err[1]) +
                          (n_err[2] - b_err[2]) + (n_err[3] - b_err[3]) + (n_stb - b_stb), 0);

        // Idle gap after a one-byte write header
        snap();
        sel(1'b1);
        send(8'h08);
        tick(20);
`ifdef NI_INTF_TMO_EN
        chk("tmo_err3", n_err[3] - b_err[3], 1);
        chk("tmo_busy", bus.busy, 1);
        send(8'h5A);
        chk("tmo_drain", n_err[1] - b_err[1], 1);
        chk("tmo_nostb", n_stb - b_stb, 0);
`else
        tick(20);
        chk("notmo_err3", n_err[3] - b_err[3], 0);
        chk("notmo_busy", bus.busy, 1);
        send(8'hA5);
        chk("notmo_stb", n_stb - b_stb, 1);
`endif
        sel(1'b0);
        chk("end_idle", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
